dx_pipeline_stage: RTL and testbench
====================================

Name: dx_pipeline_stage

Overview:
- D/X pipeline register for the 5-stage, 16-bit pipeline, with integrated load-use hazard detection, branch flush and halt drain.
- Sits between decode and execute. Its registered outputs feed the EX datapath and the EX-to-EX / MEM-to-EX forwarding logic downstream.
- Inserts bubbles and holds fetch/decode whenever forwarding alone cannot resolve a dependency.

Parameters:
- DATA_W, 16: operand/immediate width.
- REG_AW, 4: register address width; register 0 is hard-wired zero.
- DRAIN_CYCLES, 3: cycles after a halt enters D/X before halted asserts.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- D_valid  input  1  decode holds a real instruction.
- D_reg_source1, D_reg_source2, D_reg_dest  input  REG_AW  decoded register fields.
- D_uses_src1, D_uses_src2  input  1  instruction actually reads that source.
- D_RegWrite, D_MemRead, D_MemWrite, D_halt  input  1  decoded controls.
- D_data1, D_data2, D_imm  input  DATA_W  register-file read data and immediate.
- X_flush  input  1  branch/jump resolved taken in EX; kills the F and D instructions.
- D_X_valid, D_X_RegWrite, D_X_MemRead, D_X_MemWrite  output  1  registered controls.
- D_X_reg_source1, D_X_reg_source2, D_X_reg_dest  output  REG_AW  registered fields.
- D_X_data1, D_X_data2, D_X_imm  output  DATA_W  registered data.
- stall_FD  output  1  combinational; hold PC and the F/D register this cycle.
- halted  output  1  registered; pipeline drained after halt.
- stall_count  output  16  registered count of load-use stalls.

Behaviour:
- Reset (async, rst_n=0): all D_X_* outputs = 0, halted = 0, stall_count = 0, state = RUN, drain counter = 0.
- Load-use condition (combinational, all of):
  - D_X_valid & D_X_MemRead & (D_X_reg_dest != 0);
  - D_valid, and (D_uses_src1 & D_reg_source1 == D_X_reg_dest) or (D_uses_src2 & D_reg_source2 == D_X_reg_dest).
- Store exemption: the only match is src2 of a store (D_MemWrite=1, src1 not matching). No stall; the MEM-to-MEM path covers it.
- Per-cycle priority in RUN: X_flush > load-use > normal.
  - X_flush: D/X loads a bubble. Bubble means valid = 0, all controls = 0, register fields = 0, data = 0. stall_FD = 0. No count.
  - Load-use: D/X loads a bubble, stall_FD = 1, stall_count += 1 (saturates at 0xFFFF).
  - Normal: D/X loads all D_* inputs; D_X_valid = D_valid. Controls are gated with D_valid; no control is ever 1 while valid is 0.
- The registered stage adds one cycle of latency from D inputs to D_X outputs. stall_FD is combinational from current D_X and D inputs.
- FSM states: RUN, DRAIN, HALTED.
  - RUN -> DRAIN: a normal load with D_valid & D_halt. The halt itself is latched as valid with all controls 0.
  - Entering DRAIN: drain counter = DRAIN_CYCLES - 1.
  - In DRAIN: stall_FD = 1 and D/X loads bubbles. X_flush and load-use are ignored; stall_count is frozen. Counter decrements each cycle.
  - DRAIN -> HALTED: when counter = 0.
  - In HALTED: halted = 1 (registered, first cycle in HALTED), stall_FD = 1, bubbles. Remains until reset.
- Simultaneous events:
  - A halt in D with X_flush: killed, no transition.
  - A halt in D under a load-use stall: not latched until the stall clears.
- Reset mid-DRAIN or mid-HALTED: returns to RUN immediately with all outputs at their reset values.
- Register-0 rule: a load whose dest is r0 never causes a stall.

Test Plan:
- Load-use stall: LW r3 in D/X (MemRead=1, dest=3), D = ADD src1=3 -> stall_FD=1 for exactly one cycle; next D_X_valid=0; then ADD latched; stall_count=1.
- Store exemption and r0: LW r5 in D/X, D = SW src1=2, src2=5 -> stall_FD=0, SW latched next cycle. LW dest=0 with D src1=0 -> no stall.
- Flush priority: load-use condition true and X_flush=1 in the same cycle -> stall_FD=0, bubble latched, stall_count unchanged.
- Halt drain: valid halt in D at cycle N.
  - N+1: D_X_valid=1, all controls 0.
  - N+1 to N+3: stall_FD=1 with bubbles in D/X.
  - halted=1 from N+4 onward; a later X_flush pulse has no effect.
- Halt killed: D_halt=1 with X_flush=1 -> state stays RUN, halted stays 0.
- Async reset: assert rst_n=0 mid-DRAIN between clock edges -> all outputs 0 immediately. After release, normal D inputs (src1=1, data1=0x1234) are latched on the next edge.

Source files
------------

// File: rtl/dx_pipeline_stage_if.sv
// Decode-to-execute bus: decoded instruction fields coming in from decode,
// the registered D/X stage contents going out to execute, plus the
// hazard/halt status lines shared with fetch and decode.
interface dx_pipeline_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    logic              D_valid;
    logic [REG_AW-1:0] D_reg_source1;
    logic [REG_AW-1:0] D_reg_source2;
    logic [REG_AW-1:0] D_reg_dest;
    logic              D_uses_src1;
    logic              D_uses_src2;
    logic              D_RegWrite;
    logic              D_MemRead;
    logic              D_MemWrite;
    logic              D_halt;
    logic [DATA_W-1:0] D_data1;
    logic [DATA_W-1:0] D_data2;
    logic [DATA_W-1:0] D_imm;
    logic              X_flush;

    logic              D_X_valid;
    logic              D_X_RegWrite;
    logic              D_X_MemRead;
    logic              D_X_MemWrite;
    logic [REG_AW-1:0] D_X_reg_source1;
    logic [REG_AW-1:0] D_X_reg_source2;
    logic [REG_AW-1:0] D_X_reg_dest;
    logic [DATA_W-1:0] D_X_data1;
    logic [DATA_W-1:0] D_X_data2;
    logic [DATA_W-1:0] D_X_imm;
    logic              stall_FD;
    logic              halted;
    logic [15:0]       stall_count;

    // Decode side / environment: drives the D inputs, observes the stage
    modport master (
        output D_valid, D_reg_source1, D_reg_source2, D_reg_dest,
               D_uses_src1, D_uses_src2, D_RegWrite, D_MemRead, D_MemWrite,
               D_halt, D_data1, D_data2, D_imm, X_flush,
        input  D_X_valid, D_X_RegWrite, D_X_MemRead, D_X_MemWrite,
               D_X_reg_source1, D_X_reg_source2, D_X_reg_dest,
               D_X_data1, D_X_data2, D_X_imm, stall_FD, halted, stall_count
    );

    // The D/X stage itself
    modport slave (
        input  D_valid, D_reg_source1, D_reg_source2, D_reg_dest,
               D_uses_src1, D_uses_src2, D_RegWrite, D_MemRead, D_MemWrite,
               D_halt, D_data1, D_data2, D_imm, X_flush,
        output D_X_valid, D_X_RegWrite, D_X_MemRead, D_X_MemWrite,
               D_X_reg_source1, D_X_reg_source2, D_X_reg_dest,
               D_X_data1, D_X_data2, D_X_imm, stall_FD, halted, stall_count
    );
endinterface

// File: rtl/dx_pipeline_stage.sv
// D/X pipeline register with load-use hazard detection, branch flush and a
// halt drain sequence. Anything that cannot be resolved by forwarding turns
// into a bubble in D/X while fetch/decode are held.
module dx_pipeline_stage #(
    parameter int DATA_W       = 16,
    parameter int REG_AW       = 4,
    parameter int DRAIN_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    dx_pipeline_stage_if.slave dx
);
    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) + 1 : 1;

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t            state, next_state;
    logic [CW-1:0]     drain_cnt, next_drain;
    logic              halted_q;
    logic [15:0]       stall_cnt_q;

    logic              valid_q, reg_write_q, mem_read_q, mem_write_q;
    logic [REG_AW-1:0] src1_q, src2_q, dest_q;
    logic [DATA_W-1:0] data1_q, data2_q, imm_q;

    logic              take_d;
    logic              stall;
    logic              count_stall;
    logic              load_in_dx;
    logic              match1, match2;
    logic              load_use;

    // Load-use hazard: a real load with a nonzero dest sits in D/X and the
    // decode instruction reads that register. A store whose only dependency
    // is its data operand (src2) is served by the MEM-to-MEM path instead.
    always_comb begin
        load_in_dx = valid_q && mem_read_q && (dest_q != '0);
        match1     = dx.D_uses_src1 && (dx.D_reg_source1 == dest_q);
        match2     = dx.D_uses_src2 && (dx.D_reg_source2 == dest_q);
        load_use   = load_in_dx && dx.D_valid &&
                     (match1 || (match2 && !dx.D_MemWrite));
    end

    // Next-state logic: flush beats load-use beats a normal load in RUN;
    // DRAIN counts down with bubbles, HALTED holds everything until reset.
    always_comb begin
        next_state  = state;
        next_drain  = drain_cnt;
        take_d      = 1'b0;
        stall       = 1'b0;
        count_stall = 1'b0;
        case (state)
            RUN: begin
                if (dx.X_flush) begin
                    take_d = 1'b0;
                end else if (load_use) begin
                    stall       = 1'b1;
                    count_stall = 1'b1;
                end else begin
                    take_d = 1'b1;
                    if (dx.D_valid && dx.D_halt) begin
                        next_state = DRAIN;
                        next_drain = CW'(DRAIN_CYCLES - 1);
                    end
                end
            end
            DRAIN: begin
                stall = 1'b1;
                if (drain_cnt == '0) begin
                    next_state = HALTED;
                end else begin
                    next_drain = drain_cnt - 1'b1;
                end
            end
            HALTED: begin
                stall = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // State register, drain counter and the registered halted flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            drain_cnt <= '0;
            halted_q  <= 1'b0;
        end else begin
            state     <= next_state;
            drain_cnt <= next_drain;
            halted_q  <= (next_state == HALTED);
        end
    end

    // Load-use stall counter, saturating so it never wraps back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (count_stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    // D/X register: latch decode (controls gated by valid, a halt carries no
    // controls) or load an all-zero bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
        end else if (take_d) begin
            valid_q     <= dx.D_valid;
            reg_write_q <= dx.D_valid && !dx.D_halt && dx.D_RegWrite;
            mem_read_q  <= dx.D_valid && !dx.D_halt && dx.D_MemRead;
            mem_write_q <= dx.D_valid && !dx.D_halt && dx.D_MemWrite;
            src1_q      <= dx.D_reg_source1;
            src2_q      <= dx.D_reg_source2;
            dest_q      <= dx.D_reg_dest;
            data1_q     <= dx.D_data1;
            data2_q     <= dx.D_data2;
            imm_q       <= dx.D_imm;
        end else begin
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            dest_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            imm_q       <= '0;
        end
    end

    assign dx.D_X_valid       = valid_q;
    assign dx.D_X_RegWrite    = reg_write_q;
    assign dx.D_X_MemRead     = mem_read_q;
    assign dx.D_X_MemWrite    = mem_write_q;
    assign dx.D_X_reg_source1 = src1_q;
    assign dx.D_X_reg_source2 = src2_q;
    assign dx.D_X_reg_dest    = dest_q;
    assign dx.D_X_data1       = data1_q;
    assign dx.D_X_data2       = data2_q;
    assign dx.D_X_imm         = imm_q;
    assign dx.stall_FD        = stall;
    assign dx.halted          = halted_q;
    assign dx.stall_count     = stall_cnt_q;
endmodule

// File: tb/tb_dx_pipeline_stage.sv
// Directed bench for dx_pipeline_stage: load-use stalls, store/r0 exemptions,
// flush priority, halt drain, killed halt and asynchronous reset.
module tb_dx_pipeline_stage;
    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    dx_pipeline_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

    dx_pipeline_stage #(.DATA_W(16), .REG_AW(4), .DRAIN_CYCLES(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dx    (bus.slave)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(
        input logic        valid,
        input logic [3:0]  s1, s2, dest,
        input logic        u1, u2, rw, mr, mw, halt,
        input logic [15:0] d1, d2, imm,
        input logic        flush
    );
        bus.D_valid       = valid;
        bus.D_reg_source1 = s1;
        bus.D_reg_source2 = s2;
        bus.D_reg_dest    = dest;
        bus.D_uses_src1   = u1;
        bus.D_uses_src2   = u2;
        bus.D_RegWrite    = rw;
        bus.D_MemRead     = mr;
        bus.D_MemWrite    = mw;
        bus.D_halt        = halt;
        bus.D_data1       = d1;
        bus.D_data2       = d2;
        bus.D_imm         = imm;
        bus.X_flush       = flush;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                      16'h0, 16'h0, 16'h0, 1'b0);
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid",  {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("reset_dest",   {28'b0, bus.D_X_reg_dest}, 32'd0);
        checkOutput("reset_count",  {16'b0, bus.stall_count}, 32'd0);
        checkOutput("reset_halted", {31'b0, bus.halted}, 32'd0);
        checkOutput("reset_stall",  {31'b0, bus.stall_FD}, 32'd0);
        rst_n = 1'b1;

        // LW r3 followed by ADD reading r3: one bubble then the ADD
        applyStimulus(1, 4'd1, 4'd0, 4'd3, 1, 0, 1, 1, 0, 0, 16'h0010, 16'h0, 16'h0004, 0);
        tick();
        checkOutput("lw_memread", {31'b0, bus.D_X_MemRead}, 32'd1);
        checkOutput("lw_dest",    {28'b0, bus.D_X_reg_dest}, 32'd3);
        checkOutput("lw_data1",   {16'b0, bus.D_X_data1}, 32'h0010);
        applyStimulus(1, 4'd3, 4'd4, 4'd6, 1, 1, 1, 0, 0, 0, 16'h1111, 16'h2222, 16'h0, 0);
        #1;
        checkOutput("lu_stall", {31'b0, bus.stall_FD}, 32'd1);
        tick();
        checkOutput("lu_bubble_valid", {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("lu_count",        {16'b0, bus.stall_count}, 32'd1);
        checkOutput("lu_stall_clear",  {31'b0, bus.stall_FD}, 32'd0);
        tick();
        checkOutput("add_valid", {31'b0, bus.D_X_valid}, 32'd1);
        checkOutput("add_src1",  {28'b0, bus.D_X_reg_source1}, 32'd3);
        checkOutput("add_dest",  {28'b0, bus.D_X_reg_dest}, 32'd6);
        checkOutput("add_data2", {16'b0, bus.D_X_data2}, 32'h2222);

        // LW r5 then SW with src2=r5: store exemption, no stall
        applyStimulus(1, 4'd1, 4'd0, 4'd5, 1, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0008, 0);
        tick();
        applyStimulus(1, 4'd2, 4'd5, 4'd0, 1, 1, 0, 0, 1, 0, 16'hAAAA, 16'hBBBB, 16'h0002, 0);
        #1;
        checkOutput("sw_no_stall", {31'b0, bus.stall_FD}, 32'd0);
        tick();
        checkOutput("sw_memwrite", {31'b0, bus.D_X_MemWrite}, 32'd1);
        checkOutput("sw_src2",     {28'b0, bus.D_X_reg_source2}, 32'd5);
        checkOutput("sw_count",    {16'b0, bus.stall_count}, 32'd1);

        // LW to r0 never stalls
        applyStimulus(1, 4'd1, 4'd0, 4'd0, 1, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        tick();
        applyStimulus(1, 4'd0, 4'd0, 4'd7, 1, 0, 1, 0, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        #1;
        checkOutput("r0_no_stall", {31'b0, bus.stall_FD}, 32'd0);
        tick();
        checkOutput("r0_dest", {28'b0, bus.D_X_reg_dest}, 32'd7);

        // Flush wins over load-use
        applyStimulus(1, 4'd1, 4'd0, 4'd3, 1, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        tick();
        applyStimulus(1, 4'd3, 4'd0, 4'd6, 1, 0, 1, 0, 0, 0, 16'h5555, 16'h0, 16'h0, 1);
        #1;
        checkOutput("flush_no_stall", {31'b0, bus.stall_FD}, 32'd0);
        tick();
        checkOutput("flush_bubble", {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("flush_data1",  {16'b0, bus.D_X_data1}, 32'h0);
        checkOutput("flush_count",  {16'b0, bus.stall_count}, 32'd1);

        // Controls gated by D_valid
        applyStimulus(0, 4'd1, 4'd2, 4'd3, 1, 1, 1, 1, 1, 0, 16'h1, 16'h2, 16'h3, 0);
        tick();
        checkOutput("gate_valid",    {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("gate_regwrite", {31'b0, bus.D_X_RegWrite}, 32'd0);
        checkOutput("gate_memread",  {31'b0, bus.D_X_MemRead}, 32'd0);

        // Halt killed by a simultaneous flush
        applyStimulus(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0, 1);
        tick();
        checkOutput("kill_valid", {31'b0, bus.D_X_valid}, 32'd0);
        idle();
        tick();
        checkOutput("kill_halted", {31'b0, bus.halted}, 32'd0);
        checkOutput("kill_stall",  {31'b0, bus.stall_FD}, 32'd0);

        // Halt under a load-use stall waits, then drains
        applyStimulus(1, 4'd1, 4'd0, 4'd3, 1, 0, 1, 1, 0, 0, 16'h0, 16'h0, 16'h0, 0);
        tick();
        applyStimulus(1, 4'd3, 4'd0, 4'd0, 1, 0, 1, 0, 0, 1, 16'h0, 16'h0, 16'h0, 0);
        #1;
        checkOutput("halt_lu_stall", {31'b0, bus.stall_FD}, 32'd1);
        tick();
        checkOutput("halt_lu_bubble", {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("halt_lu_count",  {16'b0, bus.stall_count}, 32'd2);
        checkOutput("halt_n_stall",   {31'b0, bus.stall_FD}, 32'd0);
        tick();
        checkOutput("n1_valid",    {31'b0, bus.D_X_valid}, 32'd1);
        checkOutput("n1_regwrite", {31'b0, bus.D_X_RegWrite}, 32'd0);
        checkOutput("n1_stall",    {31'b0, bus.stall_FD}, 32'd1);
        checkOutput("n1_halted",   {31'b0, bus.halted}, 32'd0);
        applyStimulus(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 0, 0, 0, 16'h7, 16'h0, 16'h0, 1);
        tick();
        checkOutput("n2_valid",  {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("n2_stall",  {31'b0, bus.stall_FD}, 32'd1);
        checkOutput("n2_halted", {31'b0, bus.halted}, 32'd0);
        idle();
        tick();
        checkOutput("n3_stall",  {31'b0, bus.stall_FD}, 32'd1);
        checkOutput("n3_halted", {31'b0, bus.halted}, 32'd0);
        tick();
        checkOutput("n4_halted", {31'b0, bus.halted}, 32'd1);
        checkOutput("n4_stall",  {31'b0, bus.stall_FD}, 32'd1);
        checkOutput("n4_valid",  {31'b0, bus.D_X_valid}, 32'd0);
        applyStimulus(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 0, 0, 0, 16'h7, 16'h0, 16'h0, 1);
        tick();
        idle();
        tick();
        checkOutput("post_flush_halted", {31'b0, bus.halted}, 32'd1);
        checkOutput("post_flush_count",  {16'b0, bus.stall_count}, 32'd2);

        // Reset out of HALTED, then a fresh halt interrupted mid-drain
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_halted_clear", {31'b0, bus.halted}, 32'd0);
        checkOutput("rst_count_clear",  {16'b0, bus.stall_count}, 32'd0);
        tick();
        rst_n = 1'b1;
        applyStimulus(1, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0, 0, 1, 16'h0, 16'h0, 16'h0, 0);
        tick();
        idle();
        tick();
        checkOutput("drain2_stall", {31'b0, bus.stall_FD}, 32'd1);
        #3 rst_n = 1'b0;
        #1;
        checkOutput("async_valid",  {31'b0, bus.D_X_valid}, 32'd0);
        checkOutput("async_stall",  {31'b0, bus.stall_FD}, 32'd0);
        checkOutput("async_halted", {31'b0, bus.halted}, 32'd0);
        #1 rst_n = 1'b1;
        applyStimulus(1, 4'd1, 4'd0, 4'd2, 1, 0, 1, 0, 0, 0, 16'h1234, 16'h0, 16'h0, 0);
        tick();
        checkOutput("post_rst_valid", {31'b0, bus.D_X_valid}, 32'd1);
        checkOutput("post_rst_src1",  {28'b0, bus.D_X_reg_source1}, 32'd1);
        checkOutput("post_rst_data1", {16'b0, bus.D_X_data1}, 32'h1234);
        idle();
        repeat (4) tick();
        checkOutput("post_rst_run", {31'b0, bus.halted}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
